// File: rtl/tinyalu_result_checker_if.sv
// TinyALU command/response bus as seen by the in-line result checker.
// The BFM side drives everything (master); the checker only observes (slave).
interface tinyalu_result_checker_if #(
  parameter int WIDTH = 8
);
  logic                 cmd_valid;
  logic [2:0]           cmd_op;
  logic [WIDTH-1:0]     cmd_a;
  logic [WIDTH-1:0]     cmd_b;
  logic                 rsp_valid;
  logic [2*WIDTH-1:0]   rsp_result;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_valid, rsp_result
  );

  modport slave (
    input cmd_valid, cmd_op, cmd_a, cmd_b, rsp_valid, rsp_result
  );
endinterface

// File: rtl/tinyalu_result_checker.sv
// In-line TinyALU result checker: predicts each result when the command is
// accepted, queues the prediction in an in-order FIFO and compares it with the
// next DUT response. Keeps saturating pass/fail counts and sticky error flags.
module tinyalu_result_checker #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  tinyalu_result_checker_if.slave    bus,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic                       mismatch,
  output logic [2*WIDTH-1:0]         exp_result,
  output logic [2*WIDTH-1:0]         act_result,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       timeout,
  output logic                       err_any
);
  localparam int RW = 2*WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] count;
  logic [TW-1:0] tcnt;

  logic          is_pred, is_rst, empty, full;
  logic          do_pop, do_push, ovf_set, udf_set;
  logic [RW-1:0] pred, head;

  // Zero-extended result the TinyALU must produce for a given command.
  function automatic logic [RW-1:0] predict(input logic [2:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [RW-1:0] ax, bx;
    ax = RW'(a);
    bx = RW'(b);
    case (op)
      OP_ADD:  predict = ax + bx;
      OP_AND:  predict = ax & bx;
      OP_XOR:  predict = ax ^ bx;
      OP_MUL:  predict = ax * bx;
      default: predict = '0;
    endcase
  endfunction

  // Decode this cycle's strobes into FIFO actions; a pop frees a slot for a
  // same-cycle push, so push+pop is legal even when full.
  always_comb begin
    is_pred = bus.cmd_valid && (bus.cmd_op == OP_ADD || bus.cmd_op == OP_AND ||
                                bus.cmd_op == OP_XOR || bus.cmd_op == OP_MUL);
    is_rst  = bus.cmd_valid && (bus.cmd_op == OP_RST);
    empty   = (count == '0);
    full    = (count == OW'(DEPTH));
    do_pop  = bus.rsp_valid && !empty;
    do_push = is_pred && (!full || do_pop);
    ovf_set = is_pred && full && !do_pop;
    udf_set = bus.rsp_valid && empty;
    pred    = predict(bus.cmd_op, bus.cmd_a, bus.cmd_b);
    head    = mem[rd_ptr];
  end

  // Prediction storage; no reset needed, only entries behind wr_ptr are read.
  always_ff @(posedge clk) begin
    if (!clear && do_push) mem[wr_ptr] <= pred;
  end

  // Pointers, occupancy, compare results, counters and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      tcnt       <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      mismatch   <= 1'b0;
      exp_result <= '0;
      act_result <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      timeout    <= 1'b0;
    end else if (clear) begin
      // clear wins over both strobes; last compare values are left visible
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      tcnt      <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      mismatch  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (do_pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        exp_result <= head;
        act_result <= bus.rsp_result;
        if (head != bus.rsp_result) begin
          mismatch <= 1'b1;
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
        end else begin
          if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
        end
      end
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + OW'(1);
      else if (!do_push && do_pop) count <= count - OW'(1);
      // rst_op discards everything still in flight (after any same-cycle compare)
      if (is_rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end
      if (ovf_set) overflow  <= 1'b1;
      if (udf_set) underflow <= 1'b1;
      // idle-response watchdog: counts only while something is outstanding
      if (TIMEOUT == 0 || bus.rsp_valid || is_rst || empty) begin
        tcnt <= '0;
      end else if (tcnt != TW'(TIMEOUT)) begin
        tcnt <= tcnt + TW'(1);
        if (tcnt == TW'(TIMEOUT-1)) timeout <= 1'b1;
      end
    end
  end

  assign outstanding = count;
  assign err_any     = overflow | underflow | timeout | (fail_cnt != '0);

endmodule

// File: tb/tb_tinyalu_result_checker.sv
// Bench for tinyalu_result_checker: queue-based reference model, a per-cycle
// compare process, directed literal checks and a randomized stream.
module tb_tinyalu_result_checker;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n;
  logic clear;
  logic [CNT_W-1:0]           pass_cnt, fail_cnt;
  logic                       mismatch, overflow, underflow, timeout, err_any;
  logic [2*WIDTH-1:0]         exp_result, act_result;
  logic [$clog2(DEPTH+1)-1:0] outstanding;

  tinyalu_result_checker_if #(.WIDTH(WIDTH)) bus ();

  tinyalu_result_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .mismatch(mismatch),
    .exp_result(exp_result), .act_result(act_result), .outstanding(outstanding),
    .overflow(overflow), .underflow(underflow), .timeout(timeout), .err_any(err_any)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mq[$];
  int m_pass, m_fail, m_idle;
  bit m_mis, m_ovf, m_udf, m_to;
  logic [15:0] m_exp, m_act;

  function automatic logic [15:0] expect_of(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = a; ib = b;
    case (op)
      3'd1: return 16'(ia + ib);
      3'd2: return 16'(ia & ib);
      3'd3: return 16'(ia ^ ib);
      3'd4: return 16'(ia * ib);
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete(); m_pass = 0; m_fail = 0; m_idle = 0;
      m_mis = 0; m_ovf = 0; m_udf = 0; m_to = 0; m_exp = 0; m_act = 0;
    end else if (clear) begin
      mq.delete(); m_pass = 0; m_fail = 0; m_idle = 0;
      m_mis = 0; m_ovf = 0; m_udf = 0; m_to = 0;
    end else begin
      bit was_empty, is_rst;
      logic [15:0] e;
      m_mis = 0;
      was_empty = (mq.size() == 0);
      is_rst = bus.cmd_valid && bus.cmd_op == 3'd7;
      if (bus.rsp_valid) begin
        if (was_empty) m_udf = 1;
        else begin
          e = mq.pop_front();
          m_exp = e; m_act = bus.rsp_result;
          if (e == bus.rsp_result) begin if (m_pass < CMAX) m_pass++; end
          else begin m_mis = 1; if (m_fail < CMAX) m_fail++; end
        end
      end
      if (bus.cmd_valid && bus.cmd_op >= 3'd1 && bus.cmd_op <= 3'd4) begin
        if (mq.size() < DEPTH) mq.push_back(expect_of(bus.cmd_op, bus.cmd_a, bus.cmd_b));
        else m_ovf = 1;
      end
      if (is_rst) mq.delete();
      if (bus.rsp_valid || was_empty || is_rst) m_idle = 0;
      else if (m_idle < TIMEOUT) begin
        m_idle++;
        if (m_idle == TIMEOUT) m_to = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
    chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    chk("mismatch", 32'(mismatch), 32'(m_mis));
    chk("exp_result", 32'(exp_result), 32'(m_exp));
    chk("act_result", 32'(act_result), 32'(m_act));
    chk("outstanding", 32'(outstanding), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("err_any", 32'(err_any), 32'(m_ovf | m_udf | m_to | (m_fail != 0)));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit cv, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit rv, input logic [15:0] r);
    clear = 1'b0;
    bus.cmd_valid = cv; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    bus.rsp_valid = rv; bus.rsp_result = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 3'd0, 8'h0, 8'h0, 0, 16'h0);
  endtask

  task automatic do_clear();
    bus.cmd_valid = 0; bus.rsp_valid = 0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_a = 0; bus.cmd_b = 0;
    bus.rsp_valid = 0; bus.rsp_result = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset pass_cnt", 32'(pass_cnt), 0);
    chk("reset outstanding", 32'(outstanding), 0);
    chk("reset err_any", 32'(err_any), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // add with carry
    tick(1, 3'd1, 8'hFF, 8'h01, 0, 16'h0);
    tick(0, 3'd0, 8'h0, 8'h0, 1, 16'h0100);
    #1;
    chk("add pass_cnt", 32'(pass_cnt), 1);
    chk("add exp", 32'(exp_result), 32'h0100);
    chk("add act", 32'(act_result), 32'h0100);
    chk("add mismatch", 32'(mismatch), 0);
    do_clear();

    // four outstanding multiplies
    tick(1, 3'd4, 8'h03, 8'h05, 0, 16'h0);
    tick(1, 3'd4, 8'h07, 8'h09, 0, 16'h0);
    tick(1, 3'd4, 8'hFF, 8'hFF, 0, 16'h0);
    tick(1, 3'd4, 8'h00, 8'h01, 0, 16'h0);
    #1 chk("mul outstanding full", 32'(outstanding), 4);
    tick(0, 3'd0, 8'h0, 8'h0, 1, 16'd15);
    tick(0, 3'd0, 8'h0, 8'h0, 1, 16'd63);
    tick(0, 3'd0, 8'h0, 8'h0, 1, 16'hFE01);
    tick(0, 3'd0, 8'h0, 8'h0, 1, 16'h0000);
    #1;
    chk("mul pass_cnt", 32'(pass_cnt), 4);
    chk("mul outstanding drained", 32'(outstanding), 0);
    chk("mul exp last", 32'(exp_result), 32'h0000);
    do_clear();

    // xor mismatch
    tick(1, 3'd3, 8'hA5, 8'h0F, 0, 16'h0);
    tick(0, 3'd0, 8'h0, 8'h0, 1, 16'h00AB);
    #1;
    chk("xor mismatch", 32'(mismatch), 1);
    chk("xor fail_cnt", 32'(fail_cnt), 1);
    chk("xor exp", 32'(exp_result), 32'h00AA);
    chk("xor act", 32'(act_result), 32'h00AB);
    chk("xor err_any", 32'(err_any), 1);
    idle(1);
    #1 chk("xor mismatch one cycle", 32'(mismatch), 0);
    do_clear();

    // overflow, then push+pop while full
    for (int i = 0; i < 5; i++) tick(1, 3'd1, 8'(i), 8'(i), 0, 16'h0);
    #1;
    chk("ovf flag", 32'(overflow), 1);
    chk("ovf outstanding", 32'(outstanding), 4);
    tick(1, 3'd1, 8'd5, 8'd5, 1, 16'h0000);
    #1;
    chk("full push+pop outstanding", 32'(outstanding), 4);
    chk("full push+pop pass", 32'(pass_cnt), 1);
    do_clear();

    // underflow: empty, then empty with same-cycle push
    tick(0, 3'd0, 8'h0, 8'h0, 1, 16'h0);
    #1;
    chk("udf flag", 32'(underflow), 1);
    chk("udf pass", 32'(pass_cnt), 0);
    tick(1, 3'd2, 8'hF0, 8'h3C, 1, 16'h0030);
    #1;
    chk("udf push outstanding", 32'(outstanding), 1);
    chk("udf push pass", 32'(pass_cnt), 0);
    chk("udf push fail", 32'(fail_cnt), 0);
    do_clear();

    // timeout after 64 idle cycles, then clear
    tick(1, 3'd4, 8'h02, 8'h02, 0, 16'h0);
    idle(63);
    #1 chk("timeout not yet", 32'(timeout), 0);
    idle(1);
    #1 chk("timeout set", 32'(timeout), 1);
    do_clear();
    #1;
    chk("clear timeout", 32'(timeout), 0);
    chk("clear outstanding", 32'(outstanding), 0);
    chk("clear err_any", 32'(err_any), 0);

    // async reset mid-stream with 3 outstanding
    tick(1, 3'd1, 8'd1, 8'd2, 0, 16'h0);
    tick(1, 3'd1, 8'd3, 8'd4, 1, 16'd3);
    tick(1, 3'd1, 8'd5, 8'd6, 0, 16'h0);
    tick(1, 3'd1, 8'd7, 8'd8, 0, 16'h0);
    #1;
    chk("pre-reset outstanding", 32'(outstanding), 3);
    chk("pre-reset pass", 32'(pass_cnt), 1);
    bus.cmd_valid = 0; bus.rsp_valid = 0;
    #1 reset_n = 1'b0;
    #1;
    chk("async rst outstanding", 32'(outstanding), 0);
    chk("async rst pass", 32'(pass_cnt), 0);
    chk("async rst exp", 32'(exp_result), 0);
    chk("async rst act", 32'(act_result), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // randomized stream against the model
    for (int n = 0; n < 3000; n++) begin
      bit cv, rv;
      logic [15:0] r;
      if ($urandom_range(0, 149) == 0) begin
        clear = 1'b1;
      end else begin
        clear = 1'b0;
      end
      cv = ($urandom_range(0, 99) < 60);
      rv = ($urandom_range(0, 99) < 45);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) r = mq[0];
      else r = 16'($urandom);
      bus.cmd_valid = cv; bus.cmd_op = 3'($urandom_range(0, 7));
      bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom);
      bus.rsp_valid = rv; bus.rsp_result = r;
      @(negedge clk);
    end
    clear = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
